uart_fifo: RTL and testbench

Parametrised successor to the board UART. It is a full-duplex serial port with TX and RX FIFOs and valid/ready handshakes on both sides. Frame format is configurable: data width, parity mode and stop-bit count. The block detects framing errors, parity errors and RX overflow. It connects to GPIO_0[0]/GPIO_0[1] as the CPU's console/loader port, and also serves as the bench-side host model.

---
 rtl/uart_fifo.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Full-duplex UART with show-ahead TX/RX FIFOs, configurable frame format,
// and framing/parity/overflow detection on the receive side.
module uart_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          UART_RX,
   output logic                          UART_TX,
   input  logic                          tx_valid,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx_ready,
   output logic                          tx_idle,
   output logic                          rx_valid,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_frame_error,
   output logic                          rx_parity_error,
   input  logic                          rx_ready,
   output logic                          rx_overflow,
   input  logic                          clear_errors,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(2 * CLKS_PER_BIT);
   localparam int RW = DATA_BITS + 2;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
   localparam logic [3:0]    DBIT_LAST = 4'(DATA_BITS - 1);
   localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
   localparam logic          PAR_ODD   = (PARITY == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // Parity bit that makes the frame satisfy the configured odd/even rule.
   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (^d) ^ PAR_ODD;
   endfunction

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] txf_mem_q [FIFO_DEPTH];
   logic [AW-1:0]        txf_wr_q, txf_rd_q;
   logic [LW-1:0]        txf_cnt_q;
   logic                 tx_push, tx_pop;

   assign tx_ready = (txf_cnt_q != DEPTH_L);
   assign tx_push  = tx_valid && tx_ready;
   assign tx_level = txf_cnt_q;

   always_ff @(posedge clock) begin
      if (tx_push) txf_mem_q[txf_wr_q] <= tx_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         txf_wr_q  <= '0;
         txf_rd_q  <= '0;
         txf_cnt_q <= '0;
      end else begin
         if (tx_push) txf_wr_q <= txf_wr_q + AW'(1);
         if (tx_pop)  txf_rd_q <= txf_rd_q + AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   txf_cnt_q <= txf_cnt_q + LW'(1);
            2'b01:   txf_cnt_q <= txf_cnt_q - LW'(1);
            default: txf_cnt_q <= txf_cnt_q;
         endcase
      end
   end

   // ---------------- TX FSM ----------------
   state_t               tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_line_q, tx_line_d;
   logic                 tx_busy_q;
   logic                 tx_start_next;

   always_comb begin
      tx_state_d    = tx_state_q;
      tx_cnt_d      = tx_cnt_q + CW'(1);
      tx_bit_d      = tx_bit_q;
      tx_shift_d    = tx_shift_q;
      tx_par_d      = tx_par_q;
      tx_start_next = 1'b0;
      tx_pop        = 1'b0;
      tx_line_d     = 1'b1;
      case (tx_state_q)
         S_IDLE: begin
            tx_cnt_d      = '0;
            tx_start_next = (txf_cnt_q != '0);
         end
         S_START: begin
            tx_line_d = 1'b0;
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx_line_d = tx_shift_q[0];
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
               tx_bit_d   = tx_bit_q + 4'd1;
               if (tx_bit_q == DBIT_LAST)
                  tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            tx_line_d = tx_par_q;
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tx_cnt_q == STOP_LAST) begin
               tx_cnt_d      = '0;
               tx_state_d    = S_IDLE;
               tx_start_next = (txf_cnt_q != '0);
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      // Back-to-back frames reload straight from STOP without an idle bit.
      if (tx_start_next) begin
         tx_pop     = 1'b1;
         tx_shift_d = txf_mem_q[txf_rd_q];
         tx_par_d   = parity_of(txf_mem_q[txf_rd_q]);
         tx_cnt_d   = '0;
         tx_state_d = S_START;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_line_q  <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_line_q  <= tx_line_d;
         tx_busy_q  <= (tx_state_q != S_IDLE);
      end
   end

   always_ff @(posedge clock) begin
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
   end

   // The line register lags the state by a cycle, so idle waits for it too.
   assign UART_TX = tx_line_q;
   assign tx_idle = (tx_state_q == S_IDLE) && (txf_cnt_q == '0) && !tx_busy_q;

   // ---------------- RX synchroniser and FSM ----------------
   logic                 rx_meta_q, rx_sync_q, rx_prev_q;
   state_t               rx_state_q, rx_state_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_pbit_q, rx_pbit_d;
   logic                 rx_push_q, rx_push_d;
   logic [RW-1:0]        rx_word_q, rx_word_d;
   logic                 rx_perr;

   assign rx_perr = (PARITY != 0) && (parity_of(rx_shift_q) != rx_pbit_q);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CW'(1);
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_pbit_d  = rx_pbit_q;
      rx_push_d  = 1'b0;
      rx_word_d  = rx_word_q;
      case (rx_state_q)
         S_IDLE: begin
            rx_cnt_d = CW'(1);
            if (rx_prev_q && !rx_sync_q) rx_state_d = S_START;
         end
         S_START: begin
            if (rx_cnt_q == HALF_BIT) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
               rx_bit_d   = rx_bit_q + 4'd1;
               if (rx_bit_q == DBIT_LAST)
                  rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_pbit_d  = rx_sync_q;
               rx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_push_d  = 1'b1;
               rx_word_d  = {rx_perr, ~rx_sync_q, rx_shift_q};
               rx_state_d = S_IDLE;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // Synchroniser resets low so a line held low from reset never looks like a start edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_q  <= 1'b0;
         rx_sync_q  <= 1'b0;
         rx_prev_q  <= 1'b0;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_push_q  <= 1'b0;
      end else begin
         rx_meta_q  <= UART_RX;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_push_q  <= rx_push_d;
      end
   end

   always_ff @(posedge clock) begin
      rx_shift_q <= rx_shift_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_word_q  <= rx_word_d;
   end

   // ---------------- RX FIFO ----------------
   logic [RW-1:0] rxf_mem_q [FIFO_DEPTH];
   logic [AW-1:0] rxf_wr_q, rxf_rd_q;
   logic [LW-1:0] rxf_cnt_q;
   logic          rxf_full, rx_pop, rx_wr, rx_drop;
   logic          rx_ovf_q;
   logic [RW-1:0] rx_head;

   assign rxf_full = (rxf_cnt_q == DEPTH_L);
   assign rx_valid = (rxf_cnt_q != '0);
   assign rx_pop   = rx_valid && rx_ready;
   assign rx_wr    = rx_push_q && (!rxf_full || rx_pop);
   assign rx_drop  = rx_push_q && rxf_full && !rx_pop;

   always_ff @(posedge clock) begin
      if (rx_wr) rxf_mem_q[rxf_wr_q] <= rx_word_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rxf_wr_q  <= '0;
         rxf_rd_q  <= '0;
         rxf_cnt_q <= '0;
         rx_ovf_q  <= 1'b0;
      end else begin
         if (rx_wr)  rxf_wr_q <= rxf_wr_q + AW'(1);
         if (rx_pop) rxf_rd_q <= rxf_rd_q + AW'(1);
         case ({rx_wr, rx_pop})
            2'b10:   rxf_cnt_q <= rxf_cnt_q + LW'(1);
            2'b01:   rxf_cnt_q <= rxf_cnt_q - LW'(1);
            default: rxf_cnt_q <= rxf_cnt_q;
         endcase
         if (rx_drop)           rx_ovf_q <= 1'b1;
         else if (clear_errors) rx_ovf_q <= 1'b0;
      end
   end

   // Outputs are masked while empty so stale storage never shows.
   assign rx_head         = rxf_mem_q[rxf_rd_q];
   assign rx_data         = rx_valid ? rx_head[DATA_BITS-1:0] : '0;
   assign rx_frame_error  = rx_valid && rx_head[DATA_BITS];
   assign rx_parity_error = rx_valid && rx_head[DATA_BITS+1];
   assign rx_overflow     = rx_ovf_q;
   assign rx_level        = rxf_cnt_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: 8N1 instance (A) and even-parity two-stop instance (B),
// both CLKS_PER_BIT=4 and FIFO_DEPTH=4, checked against a queue-based frame model.
module tb_uart_fifo;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]      tx_valid, rx_ready, clr;
   logic [1:0][7:0] tx_data;
   wire  [1:0]      tx_ready, tx_idle, rx_valid, rx_fe, rx_pe, rx_ovf, utx;
   wire  [1:0][7:0] rx_data;
   wire  [1:0][2:0] tx_level, rx_level;
   logic            drv_line, lb_a, lb_b, sel_b;
   logic            rx_a, rx_b;

   assign rx_a = lb_a ? utx[0] : (sel_b ? 1'b1 : drv_line);
   assign rx_b = lb_b ? utx[1] : (sel_b ? drv_line : 1'b1);

   uart_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
      .clock(clk), .reset(rst), .UART_RX(rx_a), .UART_TX(utx[0]),
      .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]), .tx_idle(tx_idle[0]),
      .rx_valid(rx_valid[0]), .rx_data(rx_data[0]), .rx_frame_error(rx_fe[0]),
      .rx_parity_error(rx_pe[0]), .rx_ready(rx_ready[0]), .rx_overflow(rx_ovf[0]),
      .clear_errors(clr[0]), .tx_level(tx_level[0]), .rx_level(rx_level[0]));

   uart_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
      .clock(clk), .reset(rst), .UART_RX(rx_b), .UART_TX(utx[1]),
      .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]), .tx_idle(tx_idle[1]),
      .rx_valid(rx_valid[1]), .rx_data(rx_data[1]), .rx_frame_error(rx_fe[1]),
      .rx_parity_error(rx_pe[1]), .rx_ready(rx_ready[1]), .rx_overflow(rx_ovf[1]),
      .clear_errors(clr[1]), .tx_level(tx_level[1]), .rx_level(rx_level[1]));

   int n_checks = 0;
   int n_fail   = 0;

   // Expected received words {parity_err, frame_err, data}, per instance.
   logic [9:0] exp_a[$];
   logic [9:0] exp_b[$];
   logic [1:0] ovf_exp;
   logic [7:0] burst[4];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_push(input int u, input logic [9:0] w);
      if (u == 0) begin
         if (exp_a.size() < DEPTH) exp_a.push_back(w);
         else ovf_exp[0] = 1'b1;
      end else begin
         if (exp_b.size() < DEPTH) exp_b.push_back(w);
         else ovf_exp[1] = 1'b1;
      end
   endtask

   task automatic model_pop(input int u, output logic [9:0] w);
      w = 'x;
      if (u == 0 && exp_a.size() > 0) w = exp_a.pop_front();
      if (u == 1 && exp_b.size() > 0) w = exp_b.pop_front();
   endtask

   // Push burst[0..n-1] on consecutive edges, then find when tx_idle comes back.
   task automatic tx_burst(input int u, input int n);
      int k;
      int fl;
      fl = (u == 0) ? 10 * CPB : 12 * CPB;
      for (int i = 0; i < n; i++) begin
         tx_valid[u] = 1'b1;
         tx_data[u]  = burst[i];
         check_val("tx_ready", tx_ready[u], 1);
         model_push(u, {2'b00, burst[i]});
         @(negedge clk);
      end
      tx_valid[u] = 1'b0;
      k = n - 1;
      while (!tx_idle[u] && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check_val("tx_idle_rise", k, 2 + n * fl);
   endtask

   // Pop every word the model expects and compare it with the head.
   task automatic drain(input int u);
      int n;
      int t;
      logic [9:0] w;
      n = (u == 0) ? exp_a.size() : exp_b.size();
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!rx_valid[u] && t < 400) begin
            @(negedge clk);
            t++;
         end
         check_val("rx_valid", rx_valid[u], 1);
         model_pop(u, w);
         check_val("rx_word", {rx_pe[u], rx_fe[u], rx_data[u]}, w);
         rx_ready[u] = 1'b1;
         @(negedge clk);
         rx_ready[u] = 1'b0;
      end
      repeat (2 * CPB) @(negedge clk);
      check_val("rx_level_drained", rx_level[u], 0);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                             input logic stopv);
      drv_line = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drv_line = d[i];
         repeat (CPB) @(negedge clk);
      end
      if (has_par) begin
         drv_line = pbit;
         repeat (CPB) @(negedge clk);
      end
      drv_line = stopv;
      repeat (CPB) @(negedge clk);
      drv_line = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] fr;
      logic [7:0] d;
      logic       pb, sv;
      int         lows;

      rst = 1'b1; tx_valid = '0; tx_data = '0; rx_ready = '0; clr = '0;
      drv_line = 1'b1; lb_a = 1'b1; lb_b = 1'b0; sel_b = 1'b0; ovf_exp = '0;
      repeat (3) @(negedge clk);

      check_val("rst_tx_line", utx[0], 1);
      check_val("rst_tx_ready", tx_ready[0], 1);
      check_val("rst_tx_idle", tx_idle[0], 1);
      check_val("rst_rx_valid", rx_valid[0], 0);
      check_val("rst_rx_data", rx_data[0], 0);
      check_val("rst_flags", {rx_pe[0], rx_fe[0]}, 0);
      check_val("rst_ovf", rx_ovf[0], 0);
      check_val("rst_levels", {tx_level[0], rx_level[0]}, 0);
      check_val("rst_b_line_idle", {utx[1], tx_idle[1]}, 2'b11);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single 0xA5 frame, bit-accurate line timing relative to the push edge.
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'hA5;
      model_push(0, {2'b00, 8'hA5});
      @(negedge clk);
      tx_valid[0] = 1'b0;
      check_val("t1_tx_level", tx_level[0], 1);
      check_val("t1_idle_fall", tx_idle[0], 0);
      fr = {1'b1, 8'hA5, 1'b0};
      for (int k = 1; k <= 44; k++) begin
         @(negedge clk);
         check_val("t1_tx_line", utx[0], (k >= 2 && k < 42) ? fr[(k - 2) / CPB] : 1'b1);
         check_val("t1_tx_idle", tx_idle[0], (k >= 42) ? 1 : 0);
      end
      drain(0);

      // Loopback burst, fixed then random words.
      burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h3C;
      tx_burst(0, 4);
      drain(0);
      repeat (3) begin
         int n;
         n = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) burst[i] = 8'($urandom);
         tx_burst(0, n);
         drain(0);
      end

      // Direct drive: frame error word, then a one-cycle glitch that must be ignored.
      lb_a = 1'b0;
      repeat (8) @(negedge clk);
      send_frame(8'h41, 1'b0, 1'b0, 1'b0);
      model_push(0, {2'b01, 8'h41});
      drv_line = 1'b0;
      @(negedge clk);
      drv_line = 1'b1;
      repeat (20) @(negedge clk);
      check_val("t4_rx_level", rx_level[0], 1);
      drain(0);

      // Overflow: five random words into a depth-4 FIFO with no pops.
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom);
         send_frame(d, 1'b0, 1'b0, 1'b1);
         model_push(0, {2'b00, d});
      end
      repeat (10) @(negedge clk);
      check_val("t5_rx_level", rx_level[0], DEPTH);
      check_val("t5_ovf", rx_ovf[0], ovf_exp[0]);
      check_val("t5_head", {rx_pe[0], rx_fe[0], rx_data[0]}, exp_a[0]);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      ovf_exp[0] = 1'b0;
      check_val("t5_ovf_clear", rx_ovf[0], ovf_exp[0]);
      drain(0);

      // Even parity on instance B: fixed 0x81 cases, then random frames.
      sel_b = 1'b1;
      repeat (4) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b1, 1'b1);
      model_push(1, {2'b10, 8'h81});
      send_frame(8'h81, 1'b1, 1'b0, 1'b1);
      model_push(1, {2'b00, 8'h81});
      repeat (2) begin
         d  = 8'($urandom);
         pb = 1'($urandom);
         sv = ($urandom_range(0, 3) != 0);
         send_frame(d, 1'b1, pb, sv);
         model_push(1, {(^d) ^ pb, ~sv, d});
      end
      drain(1);

      // Instance B loopback: its own parity generation and two stop bits.
      sel_b = 1'b0;
      lb_b  = 1'b1;
      repeat (4) @(negedge clk);
      repeat (2) begin
         int n;
         n = $urandom_range(2, 4);
         for (int i = 0; i < 4; i++) burst[i] = 8'($urandom);
         tx_burst(1, n);
         drain(1);
      end

      // Reset in the middle of a TX frame with three words queued.
      lb_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tx_valid[0] = 1'b1;
         tx_data[0]  = 8'($urandom);
         @(negedge clk);
      end
      tx_valid[0] = 1'b0;
      repeat (10) @(negedge clk);
      check_val("t6_tx_level_pre", tx_level[0], 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("t6_tx_line", utx[0], 1);
      check_val("t6_tx_level", tx_level[0], 0);
      check_val("t6_tx_idle", tx_idle[0], 1);
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!utx[0]) lows++;
      end
      check_val("t6_no_start", lows, 0);
      check_val("t6_rx_valid", rx_valid[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
